fp_resize_pipe: RTL and testbench
=================================

# fp_resize_pipe

Pipelined, multi-lane IEEE-style floating-point format converter with valid/ready flow control. It generalises the team's half/single/double conversion functions into a streaming block: any input (exponent, mantissa) width to any output width, with round-to-nearest-even, proper overflow/underflow handling and per-lane status flags. It sits between the weight/activation memories and the neural-network MAC arrays, converting FP32 training data to FP16 operands and back.

## Interface
- `IN_EXP`, default 8: input exponent width.
- `IN_MAN`, default 23: input mantissa width.
- `OUT_EXP`, default 5: output exponent width.
- `OUT_MAN`, default 10: output mantissa width.
- `LANES`, default 4: independent conversion lanes per beat.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  beat presented.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in_data`  in  LANES*(1+IN_EXP+IN_MAN)  packed operands; lane 0 is in the LSBs.
- `out_valid`  out  1  result beat presented.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  LANES*(1+OUT_EXP+OUT_MAN)  converted operands.
- `out_ovf`  out  LANES  per-lane overflow (saturated).
- `out_unf`  out  LANES  per-lane underflow (flushed to zero).
- `out_inexact`  out  LANES  per-lane precision loss.

## Operation
- Biases: `BI = 2^(IN_EXP-1)-1`, `BO = 2^(OUT_EXP-1)-1`. Signed rebias `e = e_in - BI + BO` is computed at width `max(IN_EXP,OUT_EXP)+2`.
- Input exponent 0 (zero or subnormal) produces signed zero. Subnormal inputs also set `unf` and `inexact`. True zero sets no flags.
- Input exponent all-ones:
  - Mantissa 0 gives signed Inf: exponent all-ones, mantissa 0.
  - Otherwise the result is quiet NaN: sign kept, exponent all-ones, mantissa MSB=1, rest 0.
  - Neither case sets flags.
- Mantissa when `OUT_MAN >= IN_MAN`: zero-padded on the right, exact.
- Mantissa when `OUT_MAN < IN_MAN`: round-to-nearest-even using guard bit, sticky OR of the remaining bits, and the kept LSB. `inexact` is set when any dropped bit is 1. A rounding carry out of the mantissa increments `e` and clears the mantissa.
- After rounding, `e >= 2^OUT_EXP-1` gives max finite: sign kept, exponent `2^OUT_EXP-2`, mantissa all-ones. Sets `ovf` and `inexact`.
- After rounding, `e <= 0` gives signed zero (no subnormal outputs). Sets `unf` and `inexact`.
- Lanes are fully independent. Flags are sampled with their lane's data.

## Timing
- Two-stage pipeline:
  - S1 registers unpack, rebias, guard/sticky and special-case decode.
  - S2 registers the rounded, packed result and flags.
- Latency is 2 cycles from the accepting edge to `out_valid` with no backpressure. Throughput is 1 beat/cycle.
- `in_ready = !s2_valid || out_ready || !s1_valid`. A stage advances when its successor is empty or is advancing, so bubbles collapse.
- A beat is accepted when `in_valid && in_ready`. It leaves on `out_valid && out_ready`.
- While stalled (`out_valid && !out_ready`), `out_data` and the flags hold stable. Beats are never dropped or duplicated.
- `in_ready` depends combinationally on `out_ready`. This is the only input-to-output combinational path.
- On `rst`, `s1_valid`, `s2_valid` and `out_valid` clear immediately. `in_ready` is 1 and `out_data` and all flags are 0. In-flight beats are discarded.
- Datapath registers are not reset.

## Structure
- `conversions_pkg` gains:
  - Localparams for the half (5/10), single (8/23) and double (11/52) widths.
  - A `bias(exp_w)` function.
  - A `fp_flags_t` struct `{ovf, unf, inexact}`.
- Sub-module `fp_resize_lane` is purely combinational and is split into its S1 and S2 halves. The top instantiates it `LANES` times via generate and owns the valid/ready pipeline registers.

## Test plan
All scenarios use the defaults, FP32 to FP16. Each scenario lists stimulus, then the required response.
- **Basic values:** lane0 `0x3F800000` gives `0x3C00`, no flags. `0xB8800000` gives `0x8400`. `0x00000000` gives `0x0000`, no flags. `0x80000000` gives `0x8000`.
- **Rounding:** `0x3F801000` (tie) gives `0x3C00`, inexact. `0x3F803000` gives `0x3C02`, inexact. `0x3F801001` gives `0x3C01`, inexact.
- **Range limits:**
  - `0x477FE000` gives `0x7BFF`, no flags.
  - `0x477FF000` (rounds past max) gives `0x7BFF`, ovf+inexact.
  - `0x38000000` gives `0x0000`, unf+inexact.
  - `0x7F800000` gives `0x7C00`.
  - `0x7FC00001` gives `0x7E00`.
- **Throughput:** 16 back-to-back beats with `out_ready=1`. The first `out_valid` appears 2 cycles after the first accept, with 16 consecutive results in order.
- **Backpressure:** with `out_ready` held low 5 cycles mid-stream, `in_ready` drops once both stages are full and the output holds stable. After release, there is no loss or duplication (check with a scoreboard).
- **Reset mid-stream:** assert `rst` with both stages full. `out_valid` goes 0 asynchronously. After deassert, a new beat `0x3F800000` emerges after 2 cycles and no stale data appears.

Source files
------------

// File: rtl/conversions_pkg.sv
// Shared floating-point format constants, bias helper and status flag struct.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package conversions_pkg;

   localparam int HALF_EXP   = 5;
   localparam int HALF_MAN   = 10;
   localparam int SINGLE_EXP = 8;
   localparam int SINGLE_MAN = 23;
   localparam int DOUBLE_EXP = 11;
   localparam int DOUBLE_MAN = 52;

   typedef struct packed {
      logic ovf;
      logic unf;
      logic inexact;
   } fp_flags_t;

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fp_resize_pipe_lane.sv
// One conversion lane, combinational, split into a decode half (S1) and a round/pack half (S2).
// Latency: 0 cycles; the parent places registers between the halves and after S2.
// Backpressure: none here, the parent owns all flow control.
module fp_resize_lane import conversions_pkg::*; #(
   parameter int IN_EXP  = 8,
   parameter int IN_MAN  = 23,
   parameter int OUT_EXP = 5,
   parameter int OUT_MAN = 10,
   parameter int EW      = max_i(IN_EXP, OUT_EXP) + 2,
   parameter int S1W     = EW + OUT_MAN + 7
) (
   input  logic [IN_EXP+IN_MAN:0]   i_op,
   output logic [S1W-1:0]           o_s1,
   input  logic [S1W-1:0]           i_s1,
   output logic [OUT_EXP+OUT_MAN:0] o_res,
   output fp_flags_t                o_flags
);

   // Rebias constant as a two's-complement add; EW leaves headroom for the sign.
   localparam logic [EW-1:0]      REBIAS   = EW'(bias(OUT_EXP) - bias(IN_EXP));
   localparam logic [EW-1:0]      EMAX     = EW'((1 << OUT_EXP) - 1);
   localparam logic [OUT_EXP-1:0] EXP_MAXF = OUT_EXP'((1 << OUT_EXP) - 2);
   localparam logic [OUT_MAN-1:0] QNAN_MAN = OUT_MAN'(1) << (OUT_MAN - 1);

   // ---------------- S1: unpack, rebias, guard/sticky, special decode
   logic                w_sign;
   logic [IN_EXP-1:0]   w_exp_in;
   logic [IN_MAN-1:0]   w_man_in;
   logic                w_exp_zero, w_exp_ones, w_man_nz;
   logic [EW-1:0]       w_e;
   logic [OUT_MAN-1:0]  w_man;
   logic                w_guard, w_sticky;

   assign w_sign     = i_op[IN_EXP+IN_MAN];
   assign w_exp_in   = i_op[IN_MAN +: IN_EXP];
   assign w_man_in   = i_op[IN_MAN-1:0];
   assign w_exp_zero = (w_exp_in == '0);
   assign w_exp_ones = &w_exp_in;
   assign w_man_nz   = |w_man_in;
   assign w_e        = {{(EW-IN_EXP){1'b0}}, w_exp_in} + REBIAS;

   if (OUT_MAN >= IN_MAN) begin : g_pad
      // Widening mantissa: append zeros, nothing is lost.
      assign w_man    = OUT_MAN'(w_man_in) << (OUT_MAN - IN_MAN);
      assign w_guard  = 1'b0;
      assign w_sticky = 1'b0;
   end else begin : g_rnd
      localparam int D = IN_MAN - OUT_MAN;
      assign w_man   = w_man_in[IN_MAN-1 -: OUT_MAN];
      assign w_guard = w_man_in[D-1];
      if (D >= 2) begin : g_stk
         assign w_sticky = |w_man_in[D-2:0];
      end else begin : g_nostk
         assign w_sticky = 1'b0;
      end
   end

   assign o_s1 = {w_sign,
                  w_exp_zero & ~w_man_nz,   // true zero
                  w_exp_zero &  w_man_nz,   // subnormal
                  w_exp_ones & ~w_man_nz,   // infinity
                  w_exp_ones &  w_man_nz,   // NaN
                  w_guard, w_sticky, w_e, w_man};

   // ---------------- S2: round-to-nearest-even, range clamp, pack
   logic                w_s_sign, w_is_zero, w_is_sub, w_is_inf, w_is_nan;
   logic                w_s_guard, w_s_sticky;
   logic [EW-1:0]       w_s_e, w_re;
   logic [OUT_MAN-1:0]  w_s_man, w_rman;
   logic                w_round_up, w_carry, w_lost;

   assign {w_s_sign, w_is_zero, w_is_sub, w_is_inf, w_is_nan,
           w_s_guard, w_s_sticky, w_s_e, w_s_man} = i_s1;

   assign w_round_up         = w_s_guard & (w_s_sticky | w_s_man[0]);
   assign {w_carry, w_rman}  = {1'b0, w_s_man} + (OUT_MAN+1)'(w_round_up);
   assign w_re               = w_s_e + EW'(w_carry);
   assign w_lost             = w_s_guard | w_s_sticky;

   // Special cases take priority, then overflow clamp, then underflow flush.
   always_comb begin
      o_res   = {w_s_sign, w_re[OUT_EXP-1:0], w_rman};
      o_flags = '{ovf: 1'b0, unf: 1'b0, inexact: w_lost};
      if (w_is_nan) begin
         o_res   = {w_s_sign, {OUT_EXP{1'b1}}, QNAN_MAN};
         o_flags = '0;
      end else if (w_is_inf) begin
         o_res   = {w_s_sign, {OUT_EXP{1'b1}}, {OUT_MAN{1'b0}}};
         o_flags = '0;
      end else if (w_is_zero || w_is_sub) begin
         o_res   = {w_s_sign, {(OUT_EXP+OUT_MAN){1'b0}}};
         o_flags = '{ovf: 1'b0, unf: w_is_sub, inexact: w_is_sub};
      end else if ($signed(w_re) >= $signed(EMAX)) begin
         o_res   = {w_s_sign, EXP_MAXF, {OUT_MAN{1'b1}}};
         o_flags = '{ovf: 1'b1, unf: 1'b0, inexact: 1'b1};
      end else if (w_re[EW-1] || (w_re == '0)) begin
         o_res   = {w_s_sign, {(OUT_EXP+OUT_MAN){1'b0}}};
         o_flags = '{ovf: 1'b0, unf: 1'b1, inexact: 1'b1};
      end
   end

endmodule

// File: rtl/fp_resize_pipe.sv
// Multi-lane streaming float format converter (RNE rounding, saturate/flush, per-lane flags).
// Latency: 2 cycles, 1 beat/cycle; bubbles collapse.
// Backpressure: valid/ready; in_ready = !s2_valid || out_ready || !s1_valid, output held while stalled.
module fp_resize_pipe import conversions_pkg::*; #(
   parameter int IN_EXP  = 8,
   parameter int IN_MAN  = 23,
   parameter int OUT_EXP = 5,
   parameter int OUT_MAN = 10,
   parameter int LANES   = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [LANES*(1+IN_EXP+IN_MAN)-1:0]   in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [LANES*(1+OUT_EXP+OUT_MAN)-1:0] out_data,
   output logic [LANES-1:0]                     out_ovf,
   output logic [LANES-1:0]                     out_unf,
   output logic [LANES-1:0]                     out_inexact
);

   localparam int IW  = 1 + IN_EXP + IN_MAN;
   localparam int OW  = 1 + OUT_EXP + OUT_MAN;
   localparam int EW  = max_i(IN_EXP, OUT_EXP) + 2;
   localparam int S1W = EW + OUT_MAN + 7;

   logic              r_s1_vld, r_s2_vld;
   logic [S1W-1:0]    r_s1    [LANES];
   logic [OW-1:0]     r_res   [LANES];
   fp_flags_t         r_flags [LANES];

   logic [S1W-1:0]    w_s1    [LANES];
   logic [OW-1:0]     w_res   [LANES];
   fp_flags_t         w_flags [LANES];
   logic              w_s1_ld, w_s2_adv;

   assign in_ready  = !r_s2_vld || out_ready || !r_s1_vld;
   assign w_s2_adv  = !r_s2_vld || out_ready;
   assign w_s1_ld   = in_valid && in_ready;
   assign out_valid = r_s2_vld;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fp_resize_lane #(
         .IN_EXP (IN_EXP),  .IN_MAN (IN_MAN),
         .OUT_EXP(OUT_EXP), .OUT_MAN(OUT_MAN),
         .EW     (EW),      .S1W    (S1W)
      ) u_lane (
         .i_op   (in_data[g*IW +: IW]),
         .o_s1   (w_s1[g]),
         .i_s1   (r_s1[g]),
         .o_res  (w_res[g]),
         .o_flags(w_flags[g])
      );
   end

   // Stage occupancy; in_ready guarantees S1 is vacating or empty when it reloads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s2_vld <= 1'b0;
      end else begin
         if (in_ready) r_s1_vld <= in_valid;
         if (w_s2_adv) r_s2_vld <= r_s1_vld;
      end
   end

   // Datapath registers load only on an advancing stage, so a stalled output holds.
   always_ff @(posedge clk) begin
      if (w_s1_ld) r_s1 <= w_s1;
      if (w_s2_adv && r_s1_vld) begin
         r_res   <= w_res;
         r_flags <= w_flags;
      end
   end

   // Outputs are qualified by out_valid so reset shows zeros without resetting the datapath.
   always_comb begin
      out_data    = '0;
      out_ovf     = '0;
      out_unf     = '0;
      out_inexact = '0;
      if (r_s2_vld) begin
         for (int l = 0; l < LANES; l++) begin
            out_data[l*OW +: OW] = r_res[l];
            out_ovf[l]           = r_flags[l].ovf;
            out_unf[l]           = r_flags[l].unf;
            out_inexact[l]       = r_flags[l].inexact;
         end
      end
   end

endmodule

// File: tb/tb_fp_resize_pipe.sv
// Bench for fp_resize_pipe at default widths (FP32 -> FP16, 4 lanes).
// Reference model works on integer mantissa/remainder arithmetic per lane.
// Scoreboard in a negedge monitor; directed checks on the known vectors.
module tb_fp_resize_pipe;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_data;
   logic [3:0]    out_ovf, out_unf, out_inexact;

   always #5 clk = ~clk;

   fp_resize_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ovf    (out_ovf),
      .out_unf    (out_unf),
      .out_inexact(out_inexact)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [63:0] d;
      logic [3:0]  o;
      logic [3:0]  u;
      logic [3:0]  x;
   } beat_t;

   beat_t sb[$];

   // Returns {ovf, unf, inexact, result[15:0]} for one FP32 operand.
   function automatic logic [18:0] ref_lane(input logic [31:0] v);
      logic        sgn, ovf, unf, inx;
      int          ex, mm, q, rem, e;
      logic [15:0] r;
      sgn = v[31];
      ex  = int'(v[30:23]);
      mm  = int'(v[22:0]);
      ovf = 1'b0; unf = 1'b0; inx = 1'b0;
      if (ex == 255) begin
         r = (mm == 0) ? {sgn, 15'h7C00} : {sgn, 15'h7E00};
      end else if (ex == 0) begin
         r = {sgn, 15'h0};
         if (mm != 0) begin unf = 1'b1; inx = 1'b1; end
      end else begin
         q   = mm / 8192;
         rem = mm % 8192;
         if (rem > 4096 || (rem == 4096 && (q % 2) == 1)) q++;
         inx = (rem != 0);
         e   = ex - 127 + 15;
         if (q == 1024) begin q = 0; e++; end
         if (e >= 31) begin
            r = {sgn, 15'h7BFF}; ovf = 1'b1; inx = 1'b1;
         end else if (e <= 0) begin
            r = {sgn, 15'h0}; unf = 1'b1; inx = 1'b1;
         end else begin
            r = {sgn, 5'(e), 10'(q)};
         end
      end
      return {ovf, unf, inx, r};
   endfunction

   function automatic beat_t ref_beat(input logic [127:0] din);
      beat_t       b;
      logic [18:0] r;
      for (int l = 0; l < 4; l++) begin
         r = ref_lane(din[l*32 +: 32]);
         b.d[l*16 +: 16] = r[15:0];
         b.x[l] = r[16];
         b.u[l] = r[17];
         b.o[l] = r[18];
      end
      return b;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0]  ex;
      logic [22:0] mm;
      int          c;
      c  = $urandom_range(0, 9);
      mm = 23'($urandom);
      if ($urandom_range(0, 3) == 0) mm[12:0] = 13'h1000;
      case (c)
         0:       begin ex = 8'h00; if ($urandom_range(0, 1) == 0) mm = '0; end
         1:       begin ex = 8'hFF; if ($urandom_range(0, 1) == 0) mm = '0; end
         2:       ex = 8'($urandom_range(140, 150));
         3:       ex = 8'($urandom_range(105, 115));
         default: ex = 8'($urandom_range(113, 142));
      endcase
      return {1'($urandom), ex, mm};
   endfunction

   function automatic logic [127:0] rand_beat();
      return {rand_op(), rand_op(), rand_op(), rand_op()};
   endfunction

   // Monitor: scoreboard push on accept, compare on departure, hold check while stalled.
   int          n_in = 0, n_out = 0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_d;
   logic [11:0] prev_f;
   beat_t       exp_b;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (in_valid && in_ready) begin
            sb.push_back(ref_beat(in_data));
            n_in++;
         end
         if (prev_stall && out_valid) begin
            check("hold_data", out_data, prev_d);
            check("hold_flags", 64'({out_ovf, out_unf, out_inexact}), 64'(prev_f));
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               check("out_without_input", 64'(out_valid), 64'(0));
            end else begin
               exp_b = sb.pop_front();
               check("sb_data", out_data, exp_b.d);
               check("sb_ovf", 64'(out_ovf), 64'(exp_b.o));
               check("sb_unf", 64'(out_unf), 64'(exp_b.u));
               check("sb_inexact", 64'(out_inexact), 64'(exp_b.x));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         prev_f     = {out_ovf, out_unf, out_inexact};
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic drive_beat(input logic [127:0] d);
      in_valid = 1'b1;
      in_data  = d;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Sends op on lane 0 into an empty pipe and checks latency, result and flags.
   task automatic run_directed(input string tag, input logic [31:0] op,
                               input logic [15:0] res, input logic [2:0] fl);
      int lat;
      drive_beat({rand_op(), rand_op(), rand_op(), op});
      lat = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      check({tag, "_lat"}, 64'(lat), 64'(2));
      check(tag, 64'(out_data[15:0]), 64'(res));
      check({tag, "_flags"}, 64'({out_ovf[0], out_unf[0], out_inexact[0]}), 64'(fl));
      @(posedge clk); #1;
   endtask

   logic [31:0] d_op  [12] = '{32'h3F800000, 32'hB8800000, 32'h00000000, 32'h80000000,
                               32'h3F801000, 32'h3F803000, 32'h3F801001, 32'h477FE000,
                               32'h477FF000, 32'h38000000, 32'h7F800000, 32'h7FC00001};
   logic [15:0] d_res [12] = '{16'h3C00, 16'h8400, 16'h0000, 16'h8000,
                               16'h3C00, 16'h3C02, 16'h3C01, 16'h7BFF,
                               16'h7BFF, 16'h0000, 16'h7C00, 16'h7E00};
   logic [2:0]  d_fl  [12] = '{3'b000, 3'b000, 3'b000, 3'b000,
                               3'b001, 3'b001, 3'b001, 3'b000,
                               3'b101, 3'b011, 3'b000, 3'b000};

   bit done;
   int lat, run, base;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", out_data, 64'(0));
      check("rst_flags", 64'({out_ovf, out_unf, out_inexact}), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // Known-value vectors
      for (int i = 0; i < 12; i++)
         run_directed($sformatf("vec%0d", i), d_op[i], d_res[i], d_fl[i]);

      // Throughput: 16 back-to-back beats
      fork
         begin
            for (int i = 0; i < 16; i++) drive_beat(rand_beat());
         end
         begin
            for (int k = 0; k < 50; k++) begin
               @(negedge clk);
               if (in_valid && in_ready) break;
            end
            lat = 0;
            for (int k = 0; k < 10; k++) begin
               @(negedge clk);
               lat++;
               if (out_valid) break;
            end
            check("tput_latency", 64'(lat), 64'(2));
            run = 1;
            for (int k = 0; k < 15; k++) begin
               @(negedge clk);
               if (out_valid) run++;
               else break;
            end
            check("tput_consecutive", 64'(run), 64'(16));
         end
      join
      @(posedge clk); #1;

      // Backpressure: out_ready low for 5 cycles mid-stream
      fork
         begin
            for (int i = 0; i < 20; i++) drive_beat(rand_beat());
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (5) @(posedge clk); #1;

      // Random traffic with random out_ready and input gaps
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
               drive_beat(rand_beat());
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
            out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk); #1;
      check("drain_sb_empty", 64'(sb.size()), 64'(0));

      // Reset with both stages full
      out_ready = 1'b0;
      drive_beat(rand_beat());
      drive_beat(rand_beat());
      @(negedge clk);
      check("pre_rst_out_valid", 64'(out_valid), 64'(1));
      check("pre_rst_in_ready", 64'(in_ready), 64'(0));
      #2 rst = 1'b1;
      #1;
      check("async_rst_out_valid", 64'(out_valid), 64'(0));
      check("async_rst_in_ready", 64'(in_ready), 64'(1));
      check("async_rst_out_data", out_data, 64'(0));
      check("async_rst_flags", 64'({out_ovf, out_unf, out_inexact}), 64'(0));
      n_in = n_in - sb.size();
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      base = n_out;
      run_directed("post_rst", 32'h3F800000, 16'h3C00, 3'b000);
      repeat (5) @(negedge clk);
      check("post_rst_out_count", 64'(n_out - base), 64'(1));
      check("final_sb_empty", 64'(sb.size()), 64'(0));
      check("final_in_out_count", 64'(n_out), 64'(n_in));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
